// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access controller: sequences SRAM loads/stores with
// optional wait states, extends load data and stalls the pipeline meanwhile.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for mem_r/mem_w; errors pulse misalign, no SRAM cycle
// ACCESS | SRAM cycle driven (cs, oe or byte write enables)
// WAIT   | extra wait states, cs/oe/addr held, write enables released
// DONE   | access complete, load data valid from dm_do
module dm_access_unit #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       dm_do,
  output logic              dm_cs,
  output logic              dm_oe,
  output logic [3:0]        dm_web,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_di,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              stall,
  output logic              misalign
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              wr_q, wr_d;
  logic              dm_cs_q, dm_cs_d;
  logic              dm_oe_q, dm_oe_d;
  logic [3:0]        dm_web_q, dm_web_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]       dm_di_q, dm_di_d;

  logic       req, err, f3_ok, align_err;
  logic [3:0] web_new;
  logic [31:0] di_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Upper address bits are outside the SRAM window.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_W+2]};

  // Request decode: legality, alignment and lane-aligned write data.
  always_comb begin
    req = mem_r | mem_w;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = mem_r;
      default:                f3_ok = 1'b0;
    endcase
    align_err = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    err = (mem_r & mem_w) | ~f3_ok | align_err;
    case (funct3[1:0])
      2'b00: begin
        web_new = ~(4'b0001 << addr[1:0]);
        di_new  = {4{store_data[7:0]}};
      end
      2'b01: begin
        web_new = addr[1] ? 4'b0011 : 4'b1100;
        di_new  = {2{store_data[15:0]}};
      end
      default: begin
        web_new = 4'h0;
        di_new  = store_data;
      end
    endcase
  end

  // Load lane selection from the captured byte offset.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dm_do[7:0];
      2'd1:    ld_byte = dm_do[15:8];
      2'd2:    ld_byte = dm_do[23:16];
      default: ld_byte = dm_do[31:24];
    endcase
    ld_half = off_q[1] ? dm_do[31:16] : dm_do[15:0];
  end

  // Next-state, next SRAM register values and combinational handshakes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    off_d     = off_q;
    wr_d      = wr_q;
    dm_cs_d   = dm_cs_q;
    dm_oe_d   = dm_oe_q;
    dm_web_d  = dm_web_q;
    dm_addr_d = dm_addr_q;
    dm_di_d   = dm_di_q;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    load_data = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (err) begin
            misalign = 1'b1;
          end else begin
            stall     = 1'b1;
            state_d   = S_ACCESS;
            f3_d      = funct3;
            off_d     = addr[1:0];
            wr_d      = mem_w;
            dm_cs_d   = 1'b1;
            dm_oe_d   = mem_r;
            dm_web_d  = mem_w ? web_new : 4'hF;
            dm_addr_d = addr[ADDR_W+1:2];
            if (mem_w) dm_di_d = di_new;
          end
        end
      end
      S_ACCESS: begin
        stall    = 1'b1;
        dm_web_d = 4'hF;
        cnt_d    = 4'd0;
        if (WAIT_CYCLES > 0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_DONE;
          if (wr_q) begin
            dm_cs_d = 1'b0;
            dm_oe_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          state_d = S_DONE;
          if (wr_q) begin
            dm_cs_d = 1'b0;
            dm_oe_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        done    = 1'b1;
        state_d = S_IDLE;
        dm_cs_d = 1'b0;
        dm_oe_d = 1'b0;
        if (!wr_q) begin
          case (f3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = dm_do;
          endcase
        end
      end
    endcase
  end

  // State, captured request and registered SRAM interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      wr_q      <= 1'b0;
      dm_cs_q   <= 1'b0;
      dm_oe_q   <= 1'b0;
      dm_web_q  <= 4'hF;
      dm_addr_q <= '0;
      dm_di_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      dm_cs_q   <= dm_cs_d;
      dm_oe_q   <= dm_oe_d;
      dm_web_q  <= dm_web_d;
      dm_addr_q <= dm_addr_d;
      dm_di_q   <= dm_di_d;
    end
  end

  assign dm_cs   = dm_cs_q;
  assign dm_oe   = dm_oe_q;
  assign dm_web  = dm_web_q;
  assign dm_addr = dm_addr_q;
  assign dm_di   = dm_di_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: two instances (0 and 3 wait states), a reference
// model of legality/lanes/extension, and a load-result scoreboard.
module tb_dm_access_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_r [2];
  logic        mem_w [2];
  logic [2:0]  funct3 [2];
  logic [31:0] addr [2];
  logic [31:0] store_data [2];
  logic [31:0] dm_do [2];
  logic        dm_cs [2];
  logic        dm_oe [2];
  logic [3:0]  dm_web [2];
  logic [13:0] dm_addr [2];
  logic [31:0] dm_di [2];
  logic [31:0] load_data [2];
  logic        done [2];
  logic        stall [2];
  logic        misalign [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q [$];

  dm_access_unit #(.ADDR_W(14), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_r(mem_r[0]), .mem_w(mem_w[0]),
    .funct3(funct3[0]), .addr(addr[0]), .store_data(store_data[0]),
    .dm_do(dm_do[0]), .dm_cs(dm_cs[0]), .dm_oe(dm_oe[0]), .dm_web(dm_web[0]),
    .dm_addr(dm_addr[0]), .dm_di(dm_di[0]), .load_data(load_data[0]),
    .done(done[0]), .stall(stall[0]), .misalign(misalign[0])
  );

  dm_access_unit #(.ADDR_W(14), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mem_r(mem_r[1]), .mem_w(mem_w[1]),
    .funct3(funct3[1]), .addr(addr[1]), .store_data(store_data[1]),
    .dm_do(dm_do[1]), .dm_cs(dm_cs[1]), .dm_oe(dm_oe[1]), .dm_web(dm_web[1]),
    .dm_addr(dm_addr[1]), .dm_di(dm_di[1]), .load_data(load_data[1]),
    .done(done[1]), .stall(stall[1]), .misalign(misalign[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of one request.
  task automatic model(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] dov,
                       output logic err, output logic [3:0] web,
                       output logic [31:0] di, output logic [31:0] ld);
    int off;
    logic [31:0] b, h;
    off = int'(a[1:0]);
    err = 1'b0;
    if (r && w) err = 1'b1;
    if (w && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) err = 1'b1;
    if (r && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) err = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) err = 1'b1;
    if (f3 == 3'd2 && off != 0) err = 1'b1;
    web = 4'hF;
    di  = 32'h0;
    if (w) begin
      if (f3 == 3'd0) begin
        web[off] = 1'b0;
        di = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      end else if (f3 == 3'd1) begin
        web[off] = 1'b0;
        web[off + 1] = 1'b0;
        di = {sd[15:0], sd[15:0]};
      end else begin
        web = 4'h0;
        di = sd;
      end
    end
    b = (dov >> (8 * off)) & 32'hFF;
    h = (dov >> (8 * off)) & 32'hFFFF;
    ld = 32'h0;
    if (r) begin
      case (f3)
        3'd0: ld = b[7]  ? (b | 32'hFFFF_FF00) : b;
        3'd1: ld = h[15] ? (h | 32'hFFFF_0000) : h;
        3'd4: ld = b;
        3'd5: ld = h;
        default: ld = dov;
      endcase
    end
  endtask

  task automatic run_op(input int sel, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] dov);
    logic err;
    logic [3:0] web;
    logic [31:0] di, ld, got_ld;
    int lat, wr_edges;
    bit fin;
    model(r, w, f3, a, sd, dov, err, web, di, ld);
    lat = (sel == 1) ? 5 : 2;
    if (!err) sb_q.push_back(ld);
    @(posedge clk); #1;
    mem_r[sel] = r; mem_w[sel] = w; funct3[sel] = f3;
    addr[sel] = a; store_data[sel] = sd; dm_do[sel] = dov;
    #1;
    chk("stall_c0", 32'(stall[sel]), 32'(!err));
    chk("misalign_c0", 32'(misalign[sel]), 32'(err));
    if (err) begin
      mem_r[sel] = 1'b0; mem_w[sel] = 1'b0;
      @(posedge clk); #1;
      chk("err_no_cs", 32'(dm_cs[sel]), 32'd0);
      chk("err_web", 32'(dm_web[sel]), 32'hF);
      chk("err_pulse_end", 32'(misalign[sel]), 32'd0);
      return;
    end
    wr_edges = 0;
    fin = 1'b0;
    for (int n = 1; n <= 40 && !fin; n++) begin
      @(posedge clk); #1;
      if (dm_web[sel] != 4'hF) wr_edges++;
      if (n == 1) begin
        chk("acc_cs", 32'(dm_cs[sel]), 32'd1);
        chk("acc_oe", 32'(dm_oe[sel]), 32'(r));
        chk("acc_addr", 32'(dm_addr[sel]), 32'(a[15:2]));
        chk("acc_web", 32'(dm_web[sel]), 32'(web));
        if (w) chk("acc_di", dm_di[sel], di);
      end
      if (done[sel]) begin
        fin = 1'b1;
        chk("latency", n, lat);
        chk("done_stall", 32'(stall[sel]), 32'd0);
        chk("done_misalign", 32'(misalign[sel]), 32'd0);
        chk("write_edges", wr_edges, w ? 1 : 0);
        if (r) begin
          chk("done_cs_held", 32'(dm_cs[sel]), 32'd1);
          chk("done_oe_held", 32'(dm_oe[sel]), 32'd1);
        end
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          got_ld = load_data[sel];
          chk("load_data", got_ld, sb_q.pop_front());
        end
      end else begin
        chk("busy_stall", 32'(stall[sel]), 32'd1);
        chk("busy_cs", 32'(dm_cs[sel]), 32'd1);
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    mem_r[sel] = 1'b0; mem_w[sel] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mem_r[i] = 1'b0; mem_w[i] = 1'b0; funct3[i] = 3'd0;
      addr[i] = 32'h0; store_data[i] = 32'h0; dm_do[i] = 32'h0;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", 32'(dm_cs[i]), 32'd0);
      chk("rst_oe", 32'(dm_oe[i]), 32'd0);
      chk("rst_web", 32'(dm_web[i]), 32'hF);
      chk("rst_addr", 32'(dm_addr[i]), 32'd0);
      chk("rst_di", dm_di[i], 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
    end
    rst_n = 1'b1;

    // zero wait states: stores, byte/half loads, errors
    run_op(0, 1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0);
    run_op(0, 1'b0, 1'b1, 3'b000, 32'h0000_0107, 32'h0000_00A5, 32'h0);
    run_op(0, 1'b1, 1'b0, 3'b000, 32'h0000_0107, 32'h0, 32'hA512_3456);
    run_op(0, 1'b1, 1'b0, 3'b100, 32'h0000_0107, 32'h0, 32'hA512_3456);
    run_op(0, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234);
    run_op(0, 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_1234);
    run_op(0, 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0);
    run_op(0, 1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 32'h0);
    run_op(0, 1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h1234, 32'h0);
    run_op(0, 1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h55, 32'h0);
    run_op(0, 1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000_C3D2, 32'h0);
    run_op(0, 1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'hFFFF_7FFF);
    run_op(0, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00);
    run_op(0, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678);

    // three wait states
    run_op(1, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D);
    run_op(1, 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0BAD_F00D, 32'h0);
    run_op(1, 1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h0080_0000);

    // reset while a store sits in ACCESS
    @(posedge clk); #1;
    mem_w[0] = 1'b1; funct3[0] = 3'b010; addr[0] = 32'h0000_0040; store_data[0] = 32'h1111_2222;
    @(posedge clk); #1;
    chk("pre_rst_web", 32'(dm_web[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_web", 32'(dm_web[0]), 32'hF);
    chk("mid_rst_cs", 32'(dm_cs[0]), 32'd0);
    chk("mid_rst_stall", 32'(stall[0]), 32'd1);
    mem_w[0] = 1'b0;
    #1;
    chk("mid_rst_idle", 32'(stall[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h7654_3210);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
